// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester byte lanes and the UART TX FIFO write port
// shared by uart_tx_arbiter. The master view belongs to the arbiter,
// which drives the FIFO write strobe/data and the per-lane ready bits.
// The slave view belongs to the requesters and the FIFO side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_full;
  logic               wr_tx;
  logic [7:0]         w_data;

  modport master (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, wr_tx, w_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, wr_tx, w_data
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART TX FIFO write
// port between N_REQ byte-stream requesters. A winner keeps the port until
// it writes a byte flagged last, or until MAX_LEN bytes have been written
// (forced release, flagged by pkt_trunc). One idle bubble separates packets.
// Optional feature: define UART_TX_ARB_HDR_EN to prefix every granted
// packet with a header byte {4'hA, grant index}.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_arbiter_if.master    bus,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 pkt_trunc
);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_d;
  logic [ID_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]  count_q, count_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W-1:0]   cand;
  logic [7:0]        lane_data;
  logic              sel_valid;
  logic              sel_last;
  logic              at_cap;

  assign busy   = (state_q != IDLE);
  assign at_cap = (count_q == LEN_W'(MAX_LEN - 1));

  // Rotating-priority search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the granted requester's lane, valid and last bits.
  always_comb begin
    lane_data = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx_q == ID_W'(i)) begin
        lane_data = bus.req_data[8*i +: 8];
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
      end
    end
  end

  // Next-state, next-grant and FIFO write-port outputs.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant;
    gnt_idx_d     = gnt_idx_q;
    rr_ptr_d      = rr_ptr_q;
    count_d       = count_q;
    bus.wr_tx     = 1'b0;
    bus.w_data    = '0;
    bus.req_ready = '0;
    pkt_trunc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d   = N_REQ'(1) << pick_idx;
          gnt_idx_d = pick_idx;
`ifdef UART_TX_ARB_HDR_EN
          state_d   = HDR;
`else
          state_d   = XFER;
`endif
        end
      end

`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        // Header byte is not a requester byte: no ready, no count.
        if (!bus.tx_full) begin
          bus.wr_tx  = 1'b1;
          bus.w_data = {4'hA, 4'(gnt_idx_q)};
          state_d    = XFER;
        end
      end
`endif

      XFER: begin
        bus.w_data = lane_data;
        if (sel_valid && !bus.tx_full) begin
          bus.wr_tx     = 1'b1;
          bus.req_ready = grant;
          if (sel_last || at_cap) begin
            // Release the port; a cap hit without last is a truncation and
            // the rest of that stream re-arbitrates as a fresh packet.
            state_d   = IDLE;
            rr_ptr_d  = gnt_idx_q;
            grant_d   = '0;
            count_d   = '0;
            pkt_trunc = ~sel_last;
          end else begin
            count_d = count_q + LEN_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and arbitration registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant     <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= ID_W'(N_REQ - 1);
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      grant     <= grant_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, MAX_LEN=4). Inputs change
// 1 time unit after the rising edge; outputs are checked 1 unit later.
// With UART_TX_ARB_HDR_EN defined, each grant is followed by a header check.
`ifdef UART_TX_ARB_HDR_EN
`define HDR_STEP(g) hdr_step(g);
`else
`define HDR_STEP(g)
`endif

module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;

  logic clk;
  logic rst_n;
  logic [N_REQ-1:0] grant;
  logic busy;
  logic pkt_trunc;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ  (N_REQ),
    .ID_W   (2),
    .MAX_LEN(4),
    .LEN_W  (8)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .grant    (grant),
    .busy     (busy),
    .pkt_trunc(pkt_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, required end within 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    bus.req_data[8*i +: 8] = v;
  endtask

`ifdef UART_TX_ARB_HDR_EN
  task automatic hdr_step(input int g);
    logic [3:0] gi;
    gi = g[3:0];
    #1;
    chk("hdr_wr", bus.wr_tx, 1);
    chk("hdr_data", bus.w_data, {4'hA, gi});
    chk("hdr_ready", bus.req_ready, 0);
    tick();
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", bus.wr_tx, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_trunc", pkt_trunc, 0);
    rst_n = 1'b1;

    // Test 1: requester 1, bytes 11/22/33
    bus.req_valid = 4'b0010; set_lane(1, 8'h11); #1;
    chk("t1_idle_wr", bus.wr_tx, 0);
    tick(); `HDR_STEP(1) #1;
    chk("t1_grant", grant, 4'b0010);
    chk("t1_wr1", bus.wr_tx, 1);
    chk("t1_d1", bus.w_data, 8'h11);
    chk("t1_ready", bus.req_ready, 4'b0010);
    tick(); set_lane(1, 8'h22); #1;
    chk("t1_wr2", bus.wr_tx, 1);
    chk("t1_d2", bus.w_data, 8'h22);
    tick(); set_lane(1, 8'h33); bus.req_last = 4'b0010; #1;
    chk("t1_d3", bus.w_data, 8'h33);
    chk("t1_grant3", grant, 4'b0010);
    tick(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t1_busy_end", busy, 0);
    chk("t1_grant_end", grant, 0);

    // Test 2: all four requesters from reset, 1-byte packets
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus.req_valid = 4'b1111; bus.req_last = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'h40 + 8'(i));
    for (int i = 0; i < N_REQ; i++) begin
      tick(); `HDR_STEP(i) #1;
      chk("t2_grant", grant, 32'(1) << i);
      chk("t2_data", bus.w_data, 8'h40 + 8'(i));
      chk("t2_wr", bus.wr_tx, 1);
      tick(); bus.req_valid[i] = 1'b0; #1;
      chk("t2_bubble", bus.wr_tx, 0);
    end
    bus.req_valid = 4'b0101;
    tick(); `HDR_STEP(0) #1;
    chk("t2_re0", grant, 4'b0001);
    chk("t2_re0_data", bus.w_data, 8'h40);
    tick(); bus.req_valid = 4'b0100; #1;
    chk("t2_re_bubble", busy, 0);
    tick(); `HDR_STEP(2) #1;
    chk("t2_re2", grant, 4'b0100);
    chk("t2_re2_data", bus.w_data, 8'h42);
    tick(); bus.req_valid = '0; bus.req_last = '0;

    // Test 3: requester 2, 4 bytes, tx_full stall after byte 2
    bus.req_valid = 4'b0100; bus.req_last = '0; set_lane(2, 8'hB1);
    tick(); `HDR_STEP(2) #1;
    chk("t3_d1", bus.w_data, 8'hB1);
    chk("t3_grant", grant, 4'b0100);
    tick(); set_lane(2, 8'hB2); #1;
    chk("t3_d2", bus.w_data, 8'hB2);
    tick(); set_lane(2, 8'hB3); bus.tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk("t3_stall_wr", bus.wr_tx, 0);
      chk("t3_stall_ready", bus.req_ready, 0);
      chk("t3_stall_grant", grant, 4'b0100);
    end
    tick(); bus.tx_full = 1'b0; #1;
    chk("t3_wr3", bus.wr_tx, 1);
    chk("t3_d3", bus.w_data, 8'hB3);
    tick(); set_lane(2, 8'hB4); bus.req_last = 4'b0100; #1;
    chk("t3_d4", bus.w_data, 8'hB4);
    chk("t3_no_trunc", pkt_trunc, 0);
    tick(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t3_busy_end", busy, 0);

    // Test 4: requester 0, 6 bytes, forced release at byte 4
    bus.req_valid = 4'b0001; set_lane(0, 8'hC1);
    tick(); `HDR_STEP(0) #1;
    chk("t4_d1", bus.w_data, 8'hC1);
    chk("t4_trunc1", pkt_trunc, 0);
    tick(); set_lane(0, 8'hC2); #1;
    chk("t4_d2", bus.w_data, 8'hC2);
    tick(); set_lane(0, 8'hC3); #1;
    chk("t4_trunc3", pkt_trunc, 0);
    tick(); set_lane(0, 8'hC4); #1;
    chk("t4_d4", bus.w_data, 8'hC4);
    chk("t4_trunc4", pkt_trunc, 1);
    tick(); set_lane(0, 8'hC5); #1;
    chk("t4_rearb_wr", bus.wr_tx, 0);
    chk("t4_rearb_trunc", pkt_trunc, 0);
    tick(); `HDR_STEP(0) #1;
    chk("t4_d5", bus.w_data, 8'hC5);
    chk("t4_grant5", grant, 4'b0001);
    tick(); set_lane(0, 8'hC6); bus.req_last = 4'b0001; #1;
    chk("t4_d6", bus.w_data, 8'hC6);
    chk("t4_trunc6", pkt_trunc, 0);
    tick(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t4_busy_end", busy, 0);

    // Test 5: reset mid-packet, then requester 0 beats requester 3
    bus.req_valid = 4'b1000; set_lane(3, 8'hD1);
    tick(); `HDR_STEP(3) #1;
    chk("t5_grant", grant, 4'b1000);
    chk("t5_d1", bus.w_data, 8'hD1);
    tick(); set_lane(3, 8'hD2); #1;
    chk("t5_d2", bus.w_data, 8'hD2);
    rst_n = 1'b0; #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_wr", bus.wr_tx, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", bus.req_ready, 0);
    tick(); rst_n = 1'b1;
    bus.req_valid = 4'b1001; bus.req_last = 4'b0001;
    set_lane(0, 8'hE1); set_lane(3, 8'hD1); #1;
    chk("t5_idle_wr", bus.wr_tx, 0);
    tick(); `HDR_STEP(0) #1;
    chk("t5_prio", grant, 4'b0001);
    chk("t5_e1", bus.w_data, 8'hE1);
    tick(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t5_busy_end", busy, 0);

    // Test 6: requester 3 single byte 0x5A (header first when enabled)
    bus.req_valid = 4'b1000; bus.req_last = 4'b1000; set_lane(3, 8'h5A);
    tick(); `HDR_STEP(3) #1;
    chk("t6_grant", grant, 4'b1000);
    chk("t6_data", bus.w_data, 8'h5A);
    chk("t6_ready", bus.req_ready, 4'b1000);
    tick(); bus.req_valid = '0; bus.req_last = '0; #1;
    chk("t6_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
